// File: rtl/cache_victim_wb_buffer_if.sv
// Bus-side req/ack bundle carrying the victim line out of the writeback buffer.
// The master drives the beats and the slave returns the per-beat ack.
interface cache_victim_wb_buffer_if #(
    parameter int PA_BITS = 32,
    parameter int AHBW    = 64
);
    logic               BusReq;
    logic               BusAck;
    logic [PA_BITS-1:0] BusAdr;
    logic [AHBW-1:0]    BusWData;
    logic               BusLast;

    modport master (output BusReq, BusAdr, BusWData, BusLast, input BusAck);
    modport slave  (input BusReq, BusAdr, BusWData, BusLast, output BusAck);
endinterface

// File: rtl/cache_victim_wb_buffer.sv
// Single-entry victim writeback buffer: captures a dirty evicted line, then drains it
// as LINELEN/AHBW req/ack beats so the cache can start its refill immediately.
//
// state | meaning
// EMPTY | no line held; a dirty eviction is captured
// DRAIN | line held; beats are offered on the bus until the last one is acked
module cache_victim_wb_buffer #(
    parameter int NUMWAYS = 4,
    parameter int LINELEN = 256,
    parameter int AHBW    = 64,
    parameter int PA_BITS = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       CaptureEn,
    input  logic [NUMWAYS-1:0]         VictimWay,
    input  logic [NUMWAYS-1:0]         DirtyWay,
    input  logic [NUMWAYS*LINELEN-1:0] LineWays,
    input  logic [PA_BITS-1:0]         VictimAdr,
    input  logic [PA_BITS-1:0]         MatchAdr,
    cache_victim_wb_buffer_if.master   bus,
    output logic                       Busy,
    output logic                       CaptureStall,
    output logic                       Match,
    output logic                       WBDone
);
    localparam int BEATS = LINELEN / AHBW;
    localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF   = $clog2(LINELEN / 8);
    localparam logic [CNTW-1:0]    LASTCNT = CNTW'(BEATS - 1);
    localparam logic [PA_BITS-1:0] OFFMASK = PA_BITS'((1 << OFF) - 1);
    localparam logic [PA_BITS-1:0] BEATBYTES = PA_BITS'(AHBW / 8);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]         state;
    logic [CNTW-1:0]    cnt;
    logic [LINELEN-1:0] lineBuf;
    logic [PA_BITS-1:0] baseAdr;
    logic [LINELEN-1:0] selLine;
    logic               dirty;
    logic               captureFire;
    logic               isLast;

    assign dirty       = |(VictimWay & DirtyWay);
    assign captureFire = CaptureEn & dirty & (state == EMPTY);
    assign isLast      = (cnt == LASTCNT);

    // VictimWay is one-hot, so OR-ing the masked ways is a plain mux.
    always_comb begin
        selLine = '0;
        for (int i = 0; i < NUMWAYS; i++) begin
            if (VictimWay[i]) selLine = selLine | LineWays[i*LINELEN +: LINELEN];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            cnt    <= '0;
            WBDone <= 1'b0;
        end else begin
            WBDone <= 1'b0;
            case (state)
                EMPTY: begin
                    if (captureFire) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end
                end
                DRAIN: begin
                    if (bus.BusAck) begin
                        if (isLast) begin
                            state  <= EMPTY;
                            cnt    <= '0;
                            WBDone <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Payload registers carry no reset; they are only observed while Busy.
    always_ff @(posedge clk) begin
        if (captureFire) begin
            lineBuf <= selLine;
            baseAdr <= VictimAdr & ~OFFMASK;
        end
    end

    assign Busy         = (state == DRAIN);
    assign bus.BusReq   = Busy;
    assign bus.BusLast  = Busy & isLast;
    assign bus.BusWData = Busy ? lineBuf[int'(cnt)*AHBW +: AHBW] : '0;
    assign bus.BusAdr   = Busy ? (baseAdr + PA_BITS'(cnt) * BEATBYTES) : '0;
    assign CaptureStall = CaptureEn & dirty & Busy;
    assign Match        = Busy & (((MatchAdr ^ baseAdr) & ~OFFMASK) == '0);

    a_victim_onehot: assert property (@(posedge clk) disable iff (reset)
        CaptureEn |-> $onehot0(VictimWay));
endmodule

// File: tb/tb_cache_victim_wb_buffer.sv
// Randomized and directed bench for cache_victim_wb_buffer against a beat-queue reference model.
module tb_cache_victim_wb_buffer;
    localparam int NUMWAYS = 4;
    localparam int LINELEN = 256;
    localparam int AHBW    = 64;
    localparam int PA_BITS = 32;
    localparam int BEATS   = LINELEN / AHBW;
    localparam int OFF     = $clog2(LINELEN / 8);

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       CaptureEn;
    logic [NUMWAYS-1:0]         VictimWay;
    logic [NUMWAYS-1:0]         DirtyWay;
    logic [NUMWAYS*LINELEN-1:0] LineWays;
    logic [PA_BITS-1:0]         VictimAdr;
    logic [PA_BITS-1:0]         MatchAdr;
    logic                       Busy;
    logic                       CaptureStall;
    logic                       Match;
    logic                       WBDone;

    cache_victim_wb_buffer_if #(.PA_BITS(PA_BITS), .AHBW(AHBW)) bus ();

    cache_victim_wb_buffer #(
        .NUMWAYS(NUMWAYS), .LINELEN(LINELEN), .AHBW(AHBW), .PA_BITS(PA_BITS)
    ) dut (
        .clk(clk), .reset(reset), .CaptureEn(CaptureEn), .VictimWay(VictimWay),
        .DirtyWay(DirtyWay), .LineWays(LineWays), .VictimAdr(VictimAdr),
        .MatchAdr(MatchAdr), .bus(bus), .Busy(Busy), .CaptureStall(CaptureStall),
        .Match(Match), .WBDone(WBDone)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PA_BITS-1:0] adr;
        logic [AHBW-1:0]    data;
        logic               last;
    } beat_t;

    beat_t              expQ[$];
    logic               expWbDone;
    logic [PA_BITS-1:0] expBase;
    int                 nChecks = 0;
    int                 nFails  = 0;

    logic [PA_BITS-1:0] obsAdr;
    logic [AHBW-1:0]    obsData;
    logic obsReq, obsLast, obsBusy, obsStall, obsMatch, obsDone;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic fillLines();
        for (int i = 0; i < NUMWAYS*LINELEN/32; i++) LineWays[i*32 +: 32] = $urandom;
    endtask

    // One clock: drive inputs, compare at negedge against the model, then advance the model.
    task automatic cyc(input logic rst, input logic cap, input logic [NUMWAYS-1:0] vw,
                       input logic [NUMWAYS-1:0] dw, input logic [PA_BITS-1:0] va,
                       input logic [PA_BITS-1:0] ma, input logic ack);
        logic busyE, dirtyE;
        int   way;
        reset = rst; CaptureEn = cap; VictimWay = vw; DirtyWay = dw;
        VictimAdr = va; MatchAdr = ma; bus.BusAck = ack;
        @(negedge clk);
        obsAdr = bus.BusAdr; obsData = bus.BusWData; obsReq = bus.BusReq; obsLast = bus.BusLast;
        obsBusy = Busy; obsStall = CaptureStall; obsMatch = Match; obsDone = WBDone;
        busyE  = (expQ.size() != 0);
        dirtyE = |(vw & dw);
        checkVal("Busy", obsBusy, busyE);
        checkVal("BusReq", obsReq, busyE);
        checkVal("WBDone", obsDone, expWbDone);
        checkVal("CaptureStall", obsStall, cap & dirtyE & busyE);
        checkVal("Match", obsMatch, busyE && ((ma >> OFF) == (expBase >> OFF)));
        if (busyE) begin
            checkVal("BusAdr", obsAdr, expQ[0].adr);
            checkVal("BusWData", obsData, expQ[0].data);
            checkVal("BusLast", obsLast, expQ[0].last);
        end else begin
            checkVal("BusAdrIdle", obsAdr, 0);
            checkVal("BusLastIdle", obsLast, 0);
        end
        expWbDone = 1'b0;
        if (rst) begin
            expQ.delete();
        end else if (busyE) begin
            if (ack) begin
                if (expQ[0].last) expWbDone = 1'b1;
                void'(expQ.pop_front());
            end
        end else if (cap && dirtyE) begin
            way = 0;
            for (int i = 0; i < NUMWAYS; i++) if (vw[i]) way = i;
            expBase = (va >> OFF) << OFF;
            for (int k = 0; k < BEATS; k++)
                expQ.push_back('{adr: expBase + PA_BITS'(k * (AHBW/8)),
                                 data: LineWays[way*LINELEN + k*AHBW +: AHBW],
                                 last: (k == BEATS-1)});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic ack);
        cyc(1'b0, 1'b0, '0, '0, '0, 32'h0, ack);
    endtask

    logic [PA_BITS-1:0] holdAdr;
    logic [AHBW-1:0]    holdData;
    logic [AHBW-1:0]    t1Exp;
    int                 guard;

    initial begin
        reset = 1'b1; CaptureEn = 1'b0; VictimWay = '0; DirtyWay = '0;
        VictimAdr = '0; MatchAdr = '0; bus.BusAck = 1'b0;
        fillLines();
        expWbDone = 1'b0; expBase = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
        checkVal("RstBusy", obsBusy, 0);
        checkVal("RstReq", obsReq, 0);

        // T1 + T5: dirty capture of way 2, match checks while draining
        cyc(1'b0, 1'b1, 4'b0100, 4'b0100, 32'h8000_1234, 32'h0, 1'b1);
        for (int b = 0; b < BEATS; b++) begin
            cyc(1'b0, 1'b0, '0, '0, '0, (b < 2) ? 32'h8000_123C : 32'h8000_1240, 1'b1);
            t1Exp = LineWays[2*LINELEN + b*AHBW +: AHBW];
            checkVal("T1adr", obsAdr, 32'h8000_1220 + 32'(b*8));
            checkVal("T1data", obsData, t1Exp);
            checkVal("T1last", obsLast, b == BEATS-1);
            checkVal("T5match", obsMatch, b < 2);
        end
        idle(1'b1);
        checkVal("T1done", obsDone, 1);
        checkVal("T1doneMatch", obsMatch, 0);
        idle(1'b1);
        checkVal("T1doneOnce", obsDone, 0);

        // T2: clean victim dropped
        cyc(1'b0, 1'b1, 4'b0001, 4'b1110, 32'h4000_0000, 32'h0, 1'b1);
        idle(1'b1);
        checkVal("T2busy", obsBusy, 0);
        checkVal("T2req", obsReq, 0);

        // T3: backpressure on beat 1
        fillLines();
        cyc(1'b0, 1'b1, 4'b0001, 4'b0001, 32'h1234_5678, 32'h0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        holdAdr = obsAdr; holdData = obsData;
        checkVal("T3beat1adr", holdAdr, 32'h1234_5668);
        for (int s = 0; s < 4; s++) begin
            idle(1'b0);
            checkVal("T3holdAdr", obsAdr, holdAdr);
            checkVal("T3holdData", obsData, holdData);
        end
        idle(1'b1);
        checkVal("T3holdAdrAck", obsAdr, holdAdr);
        idle(1'b1);
        checkVal("T3beat2adr", obsAdr, 32'h1234_5670);
        idle(1'b1);
        idle(1'b1);

        // T4: collision during drain, retry in the WBDone cycle
        fillLines();
        cyc(1'b0, 1'b1, 4'b1000, 4'b1000, 32'h1000_0040, 32'h0, 1'b1);
        cyc(1'b0, 1'b1, 4'b0010, 4'b0010, 32'h2000_0000, 32'h0, 1'b1);
        checkVal("T4stall", obsStall, 1);
        guard = 0;
        while (!expWbDone && guard < 20) begin
            idle(1'b1);
            guard++;
        end
        if (guard >= 20) checkVal("T4timeout", 1, 0);
        cyc(1'b0, 1'b1, 4'b0010, 4'b0010, 32'h2000_0000, 32'h0, 1'b0);
        checkVal("T4doneCycle", obsDone, 1);
        checkVal("T4retryNoStall", obsStall, 0);
        idle(1'b1);
        checkVal("T4retryBusy", obsBusy, 1);
        checkVal("T4retryAdr", obsAdr, 32'h2000_0000);
        repeat (BEATS + 1) idle(1'b1);

        // T6: reset mid-drain
        cyc(1'b0, 1'b1, 4'b0100, 4'b1100, 32'hABCD_0000, 32'h0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        cyc(1'b1, 1'b0, '0, '0, '0, '0, 1'b1);
        for (int s = 0; s < 3; s++) begin
            idle(1'b1);
            checkVal("T6req", obsReq, 0);
            checkVal("T6busy", obsBusy, 0);
            checkVal("T6last", obsLast, 0);
            checkVal("T6done", obsDone, 0);
            checkVal("T6data", obsData, 0);
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [NUMWAYS-1:0] vw;
            logic [PA_BITS-1:0] ma;
            fillLines();
            vw = ($urandom_range(0, 9) == 0) ? '0 : NUMWAYS'(1 << $urandom_range(0, NUMWAYS-1));
            ma = $urandom_range(0, 1) ? expBase + PA_BITS'($urandom_range(0, 63)) : PA_BITS'($urandom);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 3, vw,
                NUMWAYS'($urandom), PA_BITS'($urandom), ma, $urandom_range(0, 9) < 6);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
